// File: rtl/kbd_pkg.sv
// kbd_pkg: widths, source counts and event-code helpers for keyboard_reader.
`default_nettype none

package kbd_pkg;

   localparam int EVENT_WIDTH = 8;

   localparam int NUM_KEYS = 23;
   localparam int NUM_JOY  = 5;
   localparam int NUM_ENC  = 4;
   localparam int NUM_BTN  = 32;

   localparam int JOY_BASE  = NUM_KEYS;
   localparam int ENCK_BASE = JOY_BASE + NUM_JOY;

   localparam logic [1:0] EV_RELEASE = 2'b00;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_ROT     = 2'b10;

   function automatic logic [EVENT_WIDTH-1:0] make_code(input logic [1:0] prefix, input int idx);
      logic [5:0] low;
      low = idx[5:0];
      return {prefix, low};
   endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_debounce.sv
// kbd_debounce: 2-flop synchroniser plus debounce for one active-low contact,
// emitting press/release pulses. Counter debounce enabled by KBD_DEBOUNCE_EN.
`default_nettype none

module kbd_debounce #(
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arm,
   input  logic raw,
   output logic press_pulse,
   output logic release_pulse
);

   logic s1;
   logic s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

`ifdef KBD_DEBOUNCE_EN
   logic       stable;
   logic [3:0] cnt;
   logic       differ;
   logic       flip;

   assign differ = (s2 != stable);
   assign flip   = arm && differ && (cnt == 4'(DEBOUNCE_CNT - 1));

   // While not armed, stable follows the incoming sample so held contacts stay silent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable <= 1'b1;
         cnt    <= '0;
      end else if (!arm) begin
         stable <= s1;
         cnt    <= '0;
      end else if (!differ) begin
         cnt <= '0;
      end else if (flip) begin
         stable <= s2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end

   assign press_pulse   = flip & ~s2;
   assign release_pulse = flip &  s2;
`else
   logic [3:0] unused_cnt;
   assign unused_cnt = 4'(DEBOUNCE_CNT);

   // Edge of the synchronised level, detected as it enters the second flop.
   assign press_pulse   = arm &  s2 & ~s1;
   assign release_pulse = arm & ~s2 &  s1;
`endif

endmodule

`default_nettype wire

// File: rtl/keyboard_reader.sv
// keyboard_reader: scans keys, joystick, encoder keys and quadrature encoders and
// serialises events into 8-bit codes. Debounce counters built when KBD_DEBOUNCE_EN is defined.
`default_nettype none

module keyboard_reader
   import kbd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_KEYS-1:0]    keysState,
   input  logic [NUM_JOY-1:0]     joystKeys,
   input  logic [NUM_ENC-1:0]     encKeys,
   input  logic [NUM_ENC-1:0]     encLinesA,
   input  logic [NUM_ENC-1:0]     encLinesB,
   output logic                   keyEventReady,
   output logic [EVENT_WIDTH-1:0] keyEvent
);

   localparam int NUM_ROT = 2 * NUM_ENC;

   logic [NUM_BTN-1:0]     raw_btn;
   logic [NUM_BTN-1:0]     press_ev;
   logic [NUM_BTN-1:0]     release_ev;
   logic [NUM_BTN-1:0]     press_pend;
   logic [NUM_BTN-1:0]     release_pend;
   logic [NUM_BTN-1:0]     press_grant;
   logic [NUM_BTN-1:0]     release_grant;
   logic [NUM_ROT-1:0]     rot_set;
   logic [NUM_ROT-1:0]     rot_pend;
   logic [NUM_ROT-1:0]     rot_grant;
   logic [NUM_ENC-1:0]     a_s1;
   logic [NUM_ENC-1:0]     a_s2;
   logic [NUM_ENC-1:0]     b_s1;
   logic [NUM_ENC-1:0]     b_s2;
   logic [1:0]             warm_cnt;
   logic                   arm;
   logic                   found;
   logic [EVENT_WIDTH-1:0] code;

   assign raw_btn = {encKeys, joystKeys, keysState};

   // Two clocks after reset the synchronisers hold real samples; edges before that are ignored.
   assign arm = (warm_cnt == 2'd2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warm_cnt <= '0;
      end else if (!arm) begin
         warm_cnt <= warm_cnt + 2'd1;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      kbd_debounce #(
         .DEBOUNCE_CNT(DEBOUNCE_CNT)
      ) u_debounce (
         .clk          (clk),
         .rst          (rst),
         .arm          (arm),
         .raw          (raw_btn[i]),
         .press_pulse  (press_ev[i]),
         .release_pulse(release_ev[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_s1 <= '1;
         a_s2 <= '1;
         b_s1 <= '1;
         b_s2 <= '1;
      end else begin
         a_s1 <= encLinesA;
         a_s2 <= a_s1;
         b_s1 <= encLinesB;
         b_s2 <= b_s1;
      end
   end

   for (genvar e = 0; e < NUM_ENC; e++) begin : g_enc
      assign rot_set[2*e]   = arm & a_s2[e] & ~a_s1[e] & ~b_s2[e];
      assign rot_set[2*e+1] = arm & a_s2[e] & ~a_s1[e] &  b_s2[e];
   end

   always_comb begin
      found         = 1'b0;
      code          = '0;
      rot_grant     = '0;
      press_grant   = '0;
      release_grant = '0;
      for (int i = 0; i < NUM_ROT; i++) begin
         if (!found && rot_pend[i]) begin
            found        = 1'b1;
            rot_grant[i] = 1'b1;
            code         = make_code(EV_ROT, i);
         end
      end
      for (int i = 0; i < NUM_BTN; i++) begin
         if (!found && press_pend[i]) begin
            found          = 1'b1;
            press_grant[i] = 1'b1;
            code           = make_code(EV_PRESS, i);
         end else if (!found && release_pend[i]) begin
            found            = 1'b1;
            release_grant[i] = 1'b1;
            code             = make_code(EV_RELEASE, i);
         end
      end
   end

   // A fresh toggle replaces whatever the opposite flag of that button still held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rot_pend      <= '0;
         press_pend    <= '0;
         release_pend  <= '0;
         keyEventReady <= 1'b0;
         keyEvent      <= '0;
      end else begin
         rot_pend      <= (rot_pend & ~rot_grant) | rot_set;
         press_pend    <= (press_pend & ~press_grant & ~release_ev) | press_ev;
         release_pend  <= (release_pend & ~release_grant & ~press_ev) | release_ev;
         keyEventReady <= found;
         if (found) begin
            keyEvent <= code;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keyboard_reader.sv
// tb_keyboard_reader: directed and randomized scenarios checked against a behavioural model.
`default_nettype none
`timescale 1ns/1ps

module tb_keyboard_reader;

   localparam int DCNT = 4;
`ifdef KBD_DEBOUNCE_EN
   localparam int LAT  = DCNT + 3;
   localparam int GAP0 = DCNT;
`else
   localparam int LAT  = 3;
   localparam int GAP0 = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [22:0] keys = '1;
   logic [4:0]  joy  = '1;
   logic [3:0]  enck = '1;
   logic [3:0]  ea   = '1;
   logic [3:0]  eb   = '1;
   logic        ready;
   logic [7:0]  ev;

   keyboard_reader #(.DEBOUNCE_CNT(DCNT)) dut (
      .clk          (clk),
      .rst          (rst),
      .keysState    (keys),
      .joystKeys    (joy),
      .encKeys      (enck),
      .encLinesA    (ea),
      .encLinesB    (eb),
      .keyEventReady(ready),
      .keyEvent     (ev)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: pending events kept as a priority-ordered set of ranks
   // (0..7 rotations, then 8+2*idx press, 9+2*idx release).
   bit   m_s1[36];
   bit   m_s2[36];
   bit   m_stab[32];
   int   m_cnt[32];
   bit   m_bs1[4];
   bit   m_bs2[4];
   bit   pend[72];
   bit   exp_ready;
   logic [7:0] exp_code;

   int         cyc_no = 0;
   int         cyc_err;
   int         e_cyc;
   logic       e_rdy, e_erdy;
   logic [7:0] e_ev, e_eev;
   logic [7:0] dut_q[$];
   int         dut_t[$];
   int         mdl_cnt;

   function automatic bit pin(input int i);
      if (i < 23) return keys[i];
      else if (i < 28) return joy[i-23];
      else if (i < 32) return enck[i-28];
      else return ea[i-32];
   endfunction

   function automatic void set_pin(input int i, input bit v);
      if (i < 23) keys[i] = v;
      else if (i < 28) joy[i-23] = v;
      else enck[i-28] = v;
   endfunction

   function automatic logic [7:0] rank_code(input int r);
      logic [7:0] c;
      if (r < 8) c = 8'h80 + 8'(r);
      else if ((r % 2) == 0) c = 8'h40 + 8'((r - 8) / 2);
      else c = 8'((r - 9) / 2);
      return c;
   endfunction

   function automatic void set_edge(input int i, input bit level);
      pend[8 + 2*i] = !level;
      pend[9 + 2*i] = level;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 36; i++) begin
         m_s1[i] = pin(i);
         m_s2[i] = pin(i);
      end
      for (int i = 0; i < 32; i++) begin
         m_stab[i] = pin(i);
         m_cnt[i]  = 0;
      end
      for (int e = 0; e < 4; e++) begin
         m_bs1[e] = eb[e];
         m_bs2[e] = eb[e];
      end
      for (int r = 0; r < 72; r++) pend[r] = 1'b0;
      exp_ready = 1'b0;
      exp_code  = 8'h00;
   endfunction

   function automatic void model_step();
      int first = -1;
      for (int r = 0; r < 72; r++) if (first < 0 && pend[r]) first = r;
      if (first >= 0) begin
         exp_ready   = 1'b1;
         exp_code    = rank_code(first);
         pend[first] = 1'b0;
      end else begin
         exp_ready = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
`ifdef KBD_DEBOUNCE_EN
         if (m_s2[i] != m_stab[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DCNT) begin
               m_stab[i] = m_s2[i];
               m_cnt[i]  = 0;
               set_edge(i, m_stab[i]);
            end
         end else begin
            m_cnt[i] = 0;
         end
`else
         if (m_s1[i] != m_s2[i]) set_edge(i, m_s1[i]);
`endif
      end
      for (int e = 0; e < 4; e++)
         if (m_s2[32+e] && !m_s1[32+e]) pend[2*e + (m_bs2[e] ? 1 : 0)] = 1'b1;
      for (int i = 0; i < 36; i++) begin
         m_s2[i] = m_s1[i];
         m_s1[i] = pin(i);
      end
      for (int e = 0; e < 4; e++) begin
         m_bs2[e] = m_bs1[e];
         m_bs1[e] = eb[e];
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc_no++;
      if (ready === 1'b1) begin
         dut_q.push_back(ev);
         dut_t.push_back(cyc_no);
      end
      if (exp_ready) mdl_cnt++;
      if (ready !== exp_ready || ev !== exp_code) begin
         if (cyc_err == 0) begin
            e_cyc = cyc_no; e_rdy = ready; e_ev = ev; e_erdy = exp_ready; e_eev = exp_code;
         end
         cyc_err++;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   function automatic void clear_obs();
      dut_q.delete();
      dut_t.delete();
      cyc_err = 0;
      mdl_cnt = 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
      clear_obs();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (ready !== 1'b0 || ev !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b ev=%h, need rdy=0 ev=00", ready, ev);
      end
      ticks(100);
      n_tests++;
      if (dut_q.size() !== 0) begin
         n_fail++;
         $display("FAIL idle_no_strobe: got %0d strobes, need 0", dut_q.size());
      end
      keys[3] = 1'b0;
      enck[1] = 1'b0;
      do_reset();
      ticks(20);
      n_tests++;
      if (dut_q.size() !== 0) begin
         n_fail++;
         $display("FAIL held_at_reset: got %0d strobes, need 0", dut_q.size());
      end
      keys[3] = 1'b1;
      enck[1] = 1'b1;
      ticks(20);
      n_tests++;
      if (dut_q.size() !== 2 || dut_q[0] !== 8'h03 || dut_q[1] !== 8'h1D) begin
         n_fail++;
         $display("FAIL held_release: got n=%0d %h %h, need n=2 03 1d", dut_q.size(), dut_q[0], dut_q[1]);
      end
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL reset_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
   endtask

   task automatic test_key_press_release();
      int t0;
      clear_obs();
      t0 = cyc_no;
      keys[5] = 1'b0;
      ticks(10);
      keys[5] = 1'b1;
      ticks(30);
      n_tests++;
      if (dut_q.size() !== 2 || dut_q[0] !== 8'h45 || dut_q[1] !== 8'h05) begin
         n_fail++;
         $display("FAIL key5_codes: got n=%0d %h %h, need n=2 45 05", dut_q.size(), dut_q[0], dut_q[1]);
      end
      n_tests++;
      if (dut_t[0] - t0 !== LAT) begin
         n_fail++;
         $display("FAIL key5_latency: got %0d cycles, need %0d", dut_t[0] - t0, LAT);
      end
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL key5_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
   endtask

   task automatic test_bounce();
      int exp_n;
`ifdef KBD_DEBOUNCE_EN
      exp_n = 0;
`else
      exp_n = 2;
`endif
      clear_obs();
      enck[2] = 1'b0;
      ticks(2);
      enck[2] = 1'b1;
      ticks(20);
      n_tests++;
      if (dut_q.size() !== exp_n || (exp_n == 2 && (dut_q[0] !== 8'h5E || dut_q[1] !== 8'h1E))) begin
         n_fail++;
         $display("FAIL bounce_short: got n=%0d %h %h, need n=%0d", dut_q.size(), dut_q[0], dut_q[1], exp_n);
      end
      clear_obs();
      enck[2] = 1'b0;
      ticks(8);
      n_tests++;
      if (dut_q.size() !== 1 || dut_q[0] !== 8'h5E) begin
         n_fail++;
         $display("FAIL bounce_held: got n=%0d %h, need n=1 5e", dut_q.size(), dut_q[0]);
      end
      enck[2] = 1'b1;
      ticks(20);
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL bounce_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
   endtask

   task automatic test_encoder();
      clear_obs();
      ea[1] = 1'b0; ticks(6);
      ea[1] = 1'b1; ticks(4);
      eb[1] = 1'b0; ticks(4);
      ea[1] = 1'b0; ticks(6);
      ea[1] = 1'b1; ticks(4);
      eb[1] = 1'b1; ticks(4);
      n_tests++;
      if (dut_q.size() !== 2 || dut_q[0] !== 8'h83 || dut_q[1] !== 8'h82) begin
         n_fail++;
         $display("FAIL enc1_codes: got n=%0d %h %h, need n=2 83 82", dut_q.size(), dut_q[0], dut_q[1]);
      end
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL enc1_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
   endtask

   task automatic test_simultaneous();
      clear_obs();
      keys[0] = 1'b0;
      joy[4]  = 1'b0;
      ea[0]   = 1'b0;
      ticks(20);
      n_tests++;
      if (dut_q.size() !== 3 || dut_q[0] !== 8'h81 || dut_q[1] !== 8'h40 || dut_q[2] !== 8'h5B) begin
         n_fail++;
         $display("FAIL simul_codes: got n=%0d %h %h %h, need 81 40 5b", dut_q.size(), dut_q[0], dut_q[1], dut_q[2]);
      end
      n_tests++;
      if (dut_t[1] - dut_t[0] !== GAP0 || dut_t[2] - dut_t[1] !== 1) begin
         n_fail++;
         $display("FAIL simul_spacing: got gaps %0d %0d, need %0d 1", dut_t[1] - dut_t[0], dut_t[2] - dut_t[1], GAP0);
      end
      keys[0] = 1'b1;
      joy[4]  = 1'b1;
      ea[0]   = 1'b1;
      ticks(20);
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL simul_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
   endtask

   task automatic test_all_sources();
      eb = 4'($urandom_range(15, 0));
      ticks(3);
      clear_obs();
      keys = '0;
      joy  = '0;
      enck = '0;
      ea   = '0;
      ticks(60);
      n_tests++;
      if (dut_q.size() !== 36 || dut_t[35] - dut_t[0] + 1 > 40) begin
         n_fail++;
         $display("FAIL all_drain: got n=%0d span=%0d, need n=36 span<=40",
                  dut_q.size(), dut_t[dut_q.size() - 1] - dut_t[0] + 1);
      end
      keys = '1;
      joy  = '1;
      enck = '1;
      ea   = '1;
      eb   = '1;
      ticks(60);
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL all_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
   endtask

   task automatic test_random();
      int ph[4];
      for (int e = 0; e < 4; e++) ph[e] = 0;
      clear_obs();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(7, 0) == 0) begin
            int i;
            i = $urandom_range(31, 0);
            set_pin(i, !pin(i));
         end
         if ($urandom_range(5, 0) == 0) begin
            int e;
            e = $urandom_range(3, 0);
            ph[e] = ($urandom_range(1, 0) == 1) ? (ph[e] + 1) % 4 : (ph[e] + 3) % 4;
            ea[e] = (ph[e] == 0 || ph[e] == 3);
            eb[e] = (ph[e] == 0 || ph[e] == 1);
         end
         tick();
      end
      keys = '1;
      joy  = '1;
      enck = '1;
      ea   = '1;
      eb   = '1;
      ticks(60);
      n_tests++;
      if (cyc_err !== 0) begin
         n_fail++;
         $display("FAIL random_cycle: %0d mismatches, first cyc %0d got %b/%h need %b/%h",
                  cyc_err, e_cyc, e_rdy, e_ev, e_erdy, e_eev);
      end
      n_tests++;
      if (dut_q.size() !== mdl_cnt) begin
         n_fail++;
         $display("FAIL random_count: got %0d strobes, need %0d", dut_q.size(), mdl_cnt);
      end
   endtask

   task automatic test_midop_reset();
      int guard;
      clear_obs();
      keys[1] = 1'b0;
      keys[2] = 1'b0;
      keys[7] = 1'b0;
      joy[0]  = 1'b0;
      guard = 0;
      while (dut_q.size() == 0 && guard < 30) begin
         tick();
         guard++;
      end
      n_tests++;
      if (dut_q.size() == 0) begin
         n_fail++;
         $display("FAIL midop_first_strobe: got none within 30 cycles, need one");
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (ready !== 1'b0 || ev !== 8'h00) begin
         n_fail++;
         $display("FAIL midop_drop: got rdy=%b ev=%h, need rdy=0 ev=00", ready, ev);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
      clear_obs();
      ticks(30);
      n_tests++;
      if (dut_q.size() !== 0 || cyc_err !== 0) begin
         n_fail++;
         $display("FAIL midop_stale: got %0d strobes %0d mismatches, need 0 0", dut_q.size(), cyc_err);
      end
   endtask

   initial begin
      test_reset();
      test_key_press_release();
      test_bounce();
      test_encoder();
      test_simultaneous();
      test_all_sources();
      test_random();
      test_midop_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
